// File: rtl/vga_text_ctrl.sv
// Write-side command sequencer for the 80x40 text display: turns PUTC/PUTN/CLEAR/SETCUR
// commands into character, colour and cursor RAM write strobes.
module vga_text_ctrl #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 40,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk25MHz,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [6:0]        cmd_x,
  input  logic [5:0]        cmd_y,
  input  logic [7:0]        cmd_char,
  input  logic [7:0]        cmd_color,
  output logic              busy,
  output logic              err,
  output logic              wren,
  output logic              wrencolor,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        wrdata,
  output logic [7:0]        wcolor,
  output logic              wrencursor,
  output logic [1:0]        wcursorAddress,
  output logic [7:0]        wcursor
);

  localparam logic [1:0]        OpPutc   = 2'd0;
  localparam logic [1:0]        OpPutn   = 2'd1;
  localparam logic [1:0]        OpClear  = 2'd2;
  localparam logic [1:0]        OpSetcur = 2'd3;
  localparam logic [6:0]        ColsX    = 7'(COLS);
  localparam logic [6:0]        LastX    = 7'(COLS - 1);
  localparam logic [5:0]        RowsY    = 6'(ROWS);
  localparam logic [5:0]        LastY    = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LastA    = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] OneA     = ADDR_W'(1);

  typedef enum logic [2:0] {StIdle, StWr, StClr, StCurX, StCurY} state_e;

  state_e              state_q, state_d;
  logic [6:0]          ptr_x_q, ptr_x_d;
  logic [5:0]          ptr_y_q, ptr_y_d;
  logic [5:0]          cur_y_q, cur_y_d;
  logic                wr_en_q, wr_en_d;
  logic                cur_en_q, cur_en_d;
  logic [1:0]          cur_addr_q, cur_addr_d;
  logic [7:0]          wcursor_q, wcursor_d;
  logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
  logic [7:0]          wrdata_q, wrdata_d;
  logic [7:0]          wcolor_q, wcolor_d;
  logic                err_q, err_d;
  logic                in_range;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x, input logic [5:0] y);
    return ADDR_W'(y) * ColsA + ADDR_W'(x);
  endfunction

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign in_range  = (cmd_x < ColsX) && (cmd_y < RowsY);

  // Strobes are decoded from the next state so they are high in the cycle after accept.
  always_comb begin
    state_d     = state_q;
    ptr_x_d     = ptr_x_q;
    ptr_y_d     = ptr_y_q;
    cur_y_d     = cur_y_q;
    wr_en_d     = 1'b0;
    cur_en_d    = 1'b0;
    cur_addr_d  = cur_addr_q;
    wcursor_d   = wcursor_q;
    wraddress_d = wraddress_q;
    wrdata_d    = wrdata_q;
    wcolor_d    = wcolor_q;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OpPutc: begin
              if (in_range) begin
                state_d     = StWr;
                wr_en_d     = 1'b1;
                wraddress_d = cell_addr(cmd_x, cmd_y);
                wrdata_d    = cmd_char;
                wcolor_d    = cmd_color;
              end else begin
                err_d = 1'b1;
              end
            end
            OpPutn: begin
              state_d     = StWr;
              wr_en_d     = 1'b1;
              wraddress_d = cell_addr(ptr_x_q, ptr_y_q);
              wrdata_d    = cmd_char;
              wcolor_d    = cmd_color;
              if (ptr_x_q == LastX) begin
                ptr_x_d = 7'd0;
                ptr_y_d = (ptr_y_q == LastY) ? 6'd0 : ptr_y_q + 6'd1;
              end else begin
                ptr_x_d = ptr_x_q + 7'd1;
              end
            end
            OpClear: begin
              state_d     = StClr;
              wr_en_d     = 1'b1;
              wraddress_d = '0;
              wrdata_d    = cmd_char;
              wcolor_d    = cmd_color;
              ptr_x_d     = 7'd0;
              ptr_y_d     = 6'd0;
            end
            OpSetcur: begin
              if (in_range) begin
                state_d    = StCurX;
                cur_en_d   = 1'b1;
                cur_addr_d = 2'd0;
                wcursor_d  = {1'b0, cmd_x};
                cur_y_d    = cmd_y;
                ptr_x_d    = cmd_x;
                ptr_y_d    = cmd_y;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      StWr: state_d = StIdle;
      StClr: begin
        // wraddress doubles as the clear counter; fill data is held in wrdata/wcolor.
        if (wraddress_q == LastA) begin
          state_d = StIdle;
        end else begin
          wr_en_d     = 1'b1;
          wraddress_d = wraddress_q + OneA;
        end
      end
      StCurX: begin
        state_d    = StCurY;
        cur_en_d   = 1'b1;
        cur_addr_d = 2'd1;
        wcursor_d  = {2'b00, cur_y_q};
      end
      StCurY: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_x_q     <= '0;
      ptr_y_q     <= '0;
      cur_y_q     <= '0;
      wr_en_q     <= 1'b0;
      cur_en_q    <= 1'b0;
      cur_addr_q  <= '0;
      wcursor_q   <= '0;
      wraddress_q <= '0;
      wrdata_q    <= '0;
      wcolor_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_x_q     <= ptr_x_d;
      ptr_y_q     <= ptr_y_d;
      cur_y_q     <= cur_y_d;
      wr_en_q     <= wr_en_d;
      cur_en_q    <= cur_en_d;
      cur_addr_q  <= cur_addr_d;
      wcursor_q   <= wcursor_d;
      wraddress_q <= wraddress_d;
      wrdata_q    <= wrdata_d;
      wcolor_q    <= wcolor_d;
      err_q       <= err_d;
    end
  end

  assign wren           = wr_en_q;
  assign wrencolor      = wr_en_q;
  assign wrencursor     = cur_en_q;
  assign wcursorAddress = cur_addr_q;
  assign wcursor        = wcursor_q;
  assign wraddress      = wraddress_q;
  assign wrdata         = wrdata_q;
  assign wcolor         = wcolor_q;
  assign err            = err_q;

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
Command sequencer that owns the write side of the 80x40 text display: character RAM, colour RAM and the two-entry cursor RAM (entry 0 = column, entry 1 = row).
- Accepts one command at a time from game/CPU logic over a valid/ready handshake.
- Converts (x,y) to linear cell addresses and drives all write strobes.
- Runs multi-cycle screen clears, and keeps an auto-advancing text pointer for streamed characters.
- Sits between game logic and the vga80x40_Altera wrapper; all of its outputs connect directly to that wrapper's write ports.

Parameters:
COLS, 80, characters per row
ROWS, 40, rows per screen
ADDR_W, 12, cell address width; must satisfy COLS*ROWS <= 2**ADDR_W

Ports:
clk25MHz  in  1  pixel/system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command this cycle
cmd_op  in  2  0=PUTC, 1=PUTN (put at pointer and advance), 2=CLEAR, 3=SETCUR
cmd_x  in  7  column, used by PUTC and SETCUR
cmd_y  in  6  row, used by PUTC and SETCUR
cmd_char  in  8  character code; for CLEAR, the fill character
cmd_color  in  8  colour byte; for CLEAR, the fill colour
busy  out  1  controller not in IDLE
err  out  1  one-cycle pulse: coordinate out of range
wren  out  1  character RAM write enable
wrencolor  out  1  colour RAM write enable
wraddress  out  ADDR_W  cell address, shared by character and colour RAMs
wrdata  out  8  character data
wcolor  out  8  colour data
wrencursor  out  1  cursor RAM write enable
wcursorAddress  out  2  cursor RAM entry: 0 = x, 1 = y
wcursor  out  8  cursor RAM data

Behaviour:
- Single clock domain clk25MHz.
- reset is asynchronous, active-high. While reset is asserted, all registers clear:
  - state=IDLE; ptr_x=0, ptr_y=0; clear counter=0.
  - All outputs 0, except cmd_ready=1.
- All write-side outputs are registered.
- Accept condition: cmd_valid && cmd_ready. cmd_ready = (state==IDLE). busy = !cmd_ready. Operands are latched on accept.
- Address rule: addr = y*COLS + x, computed at ADDR_W bits with no truncation inside range.
- Out of range: PUTC/SETCUR with x>=COLS or y>=ROWS.
  - The command is consumed and err pulses in the cycle after accept.
  - No write strobe fires and the controller stays in IDLE (cmd_ready stays 1).
- States and transitions:
  - IDLE: on accept of a valid command, go to WR (PUTC/PUTN), CLR (CLEAR) or CURX (SETCUR).
  - WR, 1 cycle: wren=wrencolor=1, wraddress=addr, wrdata=char, wcolor=color, then IDLE.
    - PUTC uses (cmd_x, cmd_y).
    - PUTN uses (ptr_x, ptr_y), then advances the pointer: x+1; if x == COLS-1 then x=0 and y+1; if y == ROWS-1 as well then y=0 (wraps to top).
    - PUTC does not move the pointer.
  - CLR: wren=wrencolor=1 every cycle, writing fill char/colour to addresses 0..COLS*ROWS-1 in order.
    - Takes COLS*ROWS cycles (3200 at default), then IDLE.
    - Sets ptr_x=ptr_y=0. The cursor RAM is untouched.
  - CURX, 1 cycle: wrencursor=1, wcursorAddress=0, wcursor={1'b0,x}.
  - CURY, 1 cycle: wrencursor=1, wcursorAddress=1, wcursor={2'b0,y}, then IDLE.
    - SETCUR also loads ptr_x=x, ptr_y=y.
- Latency, with accept in cycle N:
  - First write strobe is high in cycle N+1.
  - cmd_ready returns in N+2 for PUTC/PUTN, N+3 for SETCUR, and N+1+COLS*ROWS for CLEAR.
- Strobes are never simultaneous across groups: wren/wrencolor and wrencursor are mutually exclusive.
- In IDLE all enables are 0. wraddress/wrdata/wcolor hold their last value and are don't-care when not enabled.
- cmd_valid while busy is ignored (not latched). The requester must hold its command until ready.
- Reset during CLR or any multi-cycle state aborts immediately. Strobes go low asynchronously and no further writes occur after release.
- PUTN never errors, because the pointer is always in range.

Test Plan:
- Reset release, then PUTC x=5 y=2 char=0x41 color=0x1C -> in cycle N+1: wren=wrencolor=1, wraddress=165, wrdata=0x41, wcolor=0x1C; cmd_ready=1 in N+2.
- SETCUR x=79 y=39, then 3x PUTN 'A','B','C' -> writes at addresses 3199, 0, 1. Cursor RAM writes are addr0=0x4F then addr1=0x27, on consecutive cycles.
- CLEAR char=0x20 color=0x07 -> exactly 3200 consecutive strobe cycles, addresses 0..3199 in order; busy=1 throughout; cmd_ready=1 on cycle N+3201.
- PUTC x=80 y=0 and SETCUR x=0 y=40 -> err pulses 1 cycle each; no wren/wrencolor/wrencursor; pointer unchanged.
- Assert reset at clear address 1000 -> all enables 0 immediately. After release: cmd_ready=1, ptr=(0,0), and a PUTN writes to address 0.
- Hold cmd_valid with a different command during CLEAR -> not latched; it is accepted only on the first cycle cmd_ready=1, and its write appears one cycle later.
